fg_engine: RTL and testbench
============================

# fg_engine

Folded, pipelined f/g processing engine for the polar SC decoder. It is the parametrised successor of the fixed 8-PE combinational f/g stage. It accepts one decoding-stage job (f or g, 2^k output LLRs) and streams LLR pairs through `PE_NUM` processing elements over as many beats as the job needs. Valid/ready handshakes sit on both sides, with a registered output and a per-job done pulse. It sits between the LLR memory read port and the LLR memory write port, under control of the decoder scheduler.

## Interface
- `LLR_W`, 8, internal LLR width (two's complement)
- `PE_NUM`, 8, PE lanes per beat (power of 2, ≥1)
- `MAX_LEN`, 64, maximum output LLRs per job (power of 2, ≥`PE_NUM`)
- `LW`, $clog2(MAX_LEN)+1, width of `len_log2` (derived, do not override)

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request pulse; accepted only in IDLE.
- `flag_fg` in 1: 1 = f, 0 = g; captured on accepted `start`.
- `len_log2` in LW: job output count = 2^len_log2; captured on accepted `start`.
- `busy` out 1: high from the accepted `start` until the cycle after `done`.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_llr` in 2·PE_NUM·LLR_W: lane i uses a = word 2i, b = word 2i+1 (word 0 at LSB).
- `in_bit` in PE_NUM: partial-sum bit s for lane i (g only; ignored for f).
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_llr` out PE_NUM·LLR_W: lane i result in word i.
- `out_mask` out PE_NUM: lane-valid mask.
- `out_last` out 1: marks the final beat of the job.
- `done` out 1: one-cycle pulse on the final output handshake.

## Operation
- Beat count: BEATS = max(1, 2^L / PE_NUM), where L = min(len_log2, log2(MAX_LEN)). Out-of-range `len_log2` is clamped to MAX_LEN.
- State machine:
  - IDLE: `start` → RUN, capturing mode and BEATS; input beat counter cleared.
  - RUN: each input handshake increments the counter. The handshake for beat BEATS−1 → DRAIN.
  - DRAIN: the output handshake with `out_last` → IDLE and pulses `done`.
- `start` outside IDLE is ignored. There is no queueing.
- `in_ready` = (state==RUN) && pipeline can advance. It is 0 in IDLE and DRAIN.
- f: sign(a)⊕sign(b) applied to min(|a|,|b|). |−2^(LLR_W−1)| is taken as 2^(LLR_W−1)−1.
- g: b+a when s=0, b−a when s=1. Computed at LLR_W+1 bits, then saturated symmetrically to ±(2^(LLR_W−1)−1).
- Masking:
  - When 2^L < PE_NUM, only lanes < 2^L are valid. `out_mask` shows those lanes and inactive lanes output 0.
  - Otherwise `out_mask` is all ones.
- `out_last` is high exactly on the output beat carrying input beat BEATS−1.
- Job order is preserved. Results of one job never interleave with the next.

## Timing
- Reset (`rst` high at edge), from any state and mid-job: state=IDLE, counter=0, pipeline emptied. The in-flight job is discarded and no `done` is issued.
- Reset values: `busy`=0, `in_ready`=0, `out_valid`=0, `out_llr`=0, `out_mask`=0, `out_last`=0, `done`=0.
- Latency: an input handshake at edge n produces `out_valid` after edge n (1 stage). With FG_ENGINE_PIPE2_EN it is 2 stages.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Backpressure:
  - Output stage advances when !out_valid || out_ready.
  - `out_llr`, `out_mask` and `out_last` hold stable while out_valid && !out_ready.
- `start` in the same cycle as `done`: ignored, because state is still DRAIN. A new job can be accepted from the cycle after `done`.
- `busy` = (state!=IDLE).

## Configuration
- `FG_ENGINE_PIPE2_EN` defined:
  - An extra register sits between the |a|/|b| compare or add and the sign/saturate step.
  - Latency is 2 cycles.
  - Backpressure propagates through both stages, with no bubble at full throughput.
- Undefined: single output register, latency 1.
- Function, masking and handshakes are identical in both builds.

## Structure
- Shared package/defines file holds:
  - LLR_W default and the saturation constant LLR_MAX = 2^(LLR_W−1)−1.
  - State encodings IDLE/RUN/DRAIN.
  - Mode constants F=1, G=0.
- Sub-module `fg_pe`: one lane. Inputs a, b, s, mode; output is the saturated result. It is combinational, with an optional internal stage under the macro. `fg_engine` instantiates PE_NUM of them in a generate loop.

## Test plan
- f job with len_log2=3 (1 beat), lane0 a=5 b=−3, lane1 a=−128 b=−100 → lane0=−3, lane1=100, mask=0xFF, out_last=1, `done` 1 cycle after the handshake.
- g job with len_log2=6 (8 beats) and s alternating 0/1, a=100 b=100 → even lanes 127 (saturated), odd lanes 0; 8 beats, out_last only on beat 7, one `done`.
- len_log2=1 f job → mask=0x03, lanes 2–7 equal 0; len_log2=9 → clamped, 8 beats.
- Random `out_ready` (50%) during an 8-beat g job → no data loss or duplication, outputs stable while stalled, beat order intact.
- `start` while busy and `start` coincident with `done` → both ignored; the next `start` is accepted one cycle later.
- `rst` asserted after beat 3 of 8 → all outputs 0 next cycle, no `done`; a fresh job then completes correctly. Run the bench with and without FG_ENGINE_PIPE2_EN, checking latency 1 and 2 respectively.

Source files
------------

// File: rtl/fg_engine_pkg.sv
// fg_engine_pkg -- shared definitions for the folded f/g engine.
//   LLR_W_DEF : default internal LLR width
//   LLR_MAX   : symmetric saturation magnitude, 2^(LLR_W-1)-1
//   state_e   : engine controller states (IDLE/RUN/DRAIN)
//   MODE_F/G  : job mode encodings carried on flag_fg
// Optional build macro used by the engine: FG_ENGINE_PIPE2_EN.
package fg_engine_pkg;

  localparam int unsigned LLR_W_DEF = 8;
  localparam int unsigned LLR_MAX   = (1 << (LLR_W_DEF - 1)) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic MODE_F = 1'b1;
  localparam logic MODE_G = 1'b0;

endpackage

// File: rtl/fg_engine_pe.sv
// fg_pe -- one f/g processing lane.
//   mode : MODE_F -> sign(a)^sign(b) applied to min(|a|,|b|)
//          MODE_G -> b+a (s=0) or b-a (s=1), saturated to +/-LLR_MAX
//   a, b : input LLRs (two's complement), s : partial-sum bit
//   res  : saturated lane result
// With FG_ENGINE_PIPE2_EN defined, a register (enabled by en, cleared by
// synchronous rst) splits magnitude-compare/add from sign/saturate, and
// clk/rst/en ports exist; otherwise the lane is purely combinational.
module fg_pe
  import fg_engine_pkg::*;
#(
  parameter int unsigned LLR_W = LLR_W_DEF
) (
`ifdef FG_ENGINE_PIPE2_EN
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
`endif
  input  logic                    mode,
  input  logic                    s,
  input  logic signed [LLR_W-1:0] a,
  input  logic signed [LLR_W-1:0] b,
  output logic signed [LLR_W-1:0] res
);

  localparam logic [LLR_W-1:0]        MAXV = {1'b0, {(LLR_W-1){1'b1}}};
  localparam logic [LLR_W-1:0]        MINV = {1'b1, {(LLR_W-1){1'b0}}};
  localparam logic signed [LLR_W:0]   SMAX = {2'b00, {(LLR_W-1){1'b1}}};
  localparam logic signed [LLR_W:0]   SMIN = -SMAX;

  // First half: magnitudes / wide sum
  logic [LLR_W-1:0]      mag_a, mag_b, pre_mag;
  logic                  pre_sgn;
  logic signed [LLR_W:0] ae, be, pre_sum;

  always_comb begin
    // The most negative code has no positive twin; treat it as LLR_MAX.
    mag_a   = a[LLR_W-1] ? ((a == MINV) ? MAXV : LLR_W'(-a)) : a;
    mag_b   = b[LLR_W-1] ? ((b == MINV) ? MAXV : LLR_W'(-b)) : b;
    pre_mag = (mag_a < mag_b) ? mag_a : mag_b;
    pre_sgn = a[LLR_W-1] ^ b[LLR_W-1];
    ae      = {a[LLR_W-1], a};
    be      = {b[LLR_W-1], b};
    pre_sum = s ? (be - ae) : (be + ae);
  end

  // Second half operands, registered or passed through
  logic                  st_mode, st_sgn;
  logic [LLR_W-1:0]      st_mag;
  logic signed [LLR_W:0] st_sum;

`ifdef FG_ENGINE_PIPE2_EN
  logic                  mode_q, sgn_q;
  logic [LLR_W-1:0]      mag_q;
  logic signed [LLR_W:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      sgn_q  <= 1'b0;
      mag_q  <= '0;
      sum_q  <= '0;
    end else if (en) begin
      mode_q <= mode;
      sgn_q  <= pre_sgn;
      mag_q  <= pre_mag;
      sum_q  <= pre_sum;
    end
  end

  assign st_mode = mode_q;
  assign st_sgn  = sgn_q;
  assign st_mag  = mag_q;
  assign st_sum  = sum_q;
`else
  assign st_mode = mode;
  assign st_sgn  = pre_sgn;
  assign st_mag  = pre_mag;
  assign st_sum  = pre_sum;
`endif

  logic signed [LLR_W-1:0] mag_s, f_res;
  logic signed [LLR_W:0]   sat;

  always_comb begin
    mag_s = st_mag;
    f_res = st_sgn ? -mag_s : mag_s;
    if (st_sum > SMAX)      sat = SMAX;
    else if (st_sum < SMIN) sat = SMIN;
    else                    sat = st_sum;
    res = (st_mode == MODE_G) ? sat[LLR_W-1:0] : f_res;
  end

endmodule

// File: rtl/fg_engine.sv
// fg_engine -- folded, pipelined f/g engine for the polar SC decoder.
//   clk, rst          : clock, synchronous active-high reset
//   start, flag_fg,
//   len_log2          : job request (accepted in IDLE), mode, log2 output count
//   busy              : job in progress (state != IDLE)
//   in_valid/in_ready : input beat handshake; in_llr = 2*PE_NUM words (a,b per lane),
//                       in_bit = per-lane partial-sum bit
//   out_valid/out_ready: output beat handshake; out_llr = PE_NUM results,
//                       out_mask = valid lanes, out_last = final beat
//   done              : pulse on the final output handshake
// Build macro FG_ENGINE_PIPE2_EN: two-stage datapath (latency 2) instead of
// a single output register (latency 1).
module fg_engine
  import fg_engine_pkg::*;
#(
  parameter int unsigned LLR_W   = LLR_W_DEF,
  parameter int unsigned PE_NUM  = 8,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LW      = $clog2(MAX_LEN) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       flag_fg,
  input  logic [LW-1:0]              len_log2,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*PE_NUM*LLR_W-1:0]  in_llr,
  input  logic [PE_NUM-1:0]          in_bit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PE_NUM*LLR_W-1:0]    out_llr,
  output logic [PE_NUM-1:0]          out_mask,
  output logic                       out_last,
  output logic                       done
);

  localparam int unsigned LOG2_MAX  = $clog2(MAX_LEN);
  localparam int unsigned LOG2_PE   = $clog2(PE_NUM);
  localparam int unsigned MAX_BEATS = MAX_LEN / PE_NUM;
  localparam int unsigned CW        = $clog2(MAX_BEATS) + 1;
  localparam logic [LW-1:0] LOG2_MAX_LW = LW'(LOG2_MAX);
  localparam logic [LW-1:0] LOG2_PE_LW  = LW'(LOG2_PE);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, beats_m1_q, beats_m1_d;
  logic                mode_q, mode_d;
  logic [PE_NUM-1:0]   mask_q, mask_d;

  logic                       out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [PE_NUM*LLR_W-1:0]    out_llr_q, out_llr_d;
  logic [PE_NUM-1:0]          out_mask_q, out_mask_d;

  logic adv_o, in_fire, is_last_in, done_w;

  assign adv_o      = !out_valid_q || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign is_last_in = (cnt_q == beats_m1_q);
  assign done_w     = out_valid_q && out_ready && out_last_q && (state_q == ST_DRAIN);

`ifdef FG_ENGINE_PIPE2_EN
  logic v1_q, v1_d, last1_q, last1_d, adv_1;
  assign adv_1    = !v1_q || adv_o;
  assign in_ready = (state_q == ST_RUN) && adv_1;
`else
  assign in_ready = (state_q == ST_RUN) && adv_o;
`endif

  // Job geometry decoded from the request
  logic [LW-1:0]     len_cl;
  logic [CW-1:0]     beats_m1_start;
  logic [PE_NUM-1:0] mask_start;

  always_comb begin
    len_cl = (len_log2 > LOG2_MAX_LW) ? LOG2_MAX_LW : len_log2;
    if (len_cl >= LOG2_PE_LW) begin
      beats_m1_start = (CW'(1) << (len_cl - LOG2_PE_LW)) - CW'(1);
      mask_start     = '1;
    end else begin
      beats_m1_start = '0;
      mask_start     = ~({PE_NUM{1'b1}} << (1 << len_cl));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    beats_m1_d = beats_m1_q;
    mask_d     = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          mode_d     = flag_fg;
          beats_m1_d = beats_m1_start;
          mask_d     = mask_start;
        end
      end
      ST_RUN: begin
        if (in_fire) begin
          cnt_d = cnt_q + CW'(1);
          if (is_last_in) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (done_w) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane array
  logic [LLR_W-1:0]        pe_res [PE_NUM];
  logic [PE_NUM*LLR_W-1:0] lanes_masked;

  for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_pe
    fg_pe #(.LLR_W(LLR_W)) u_pe (
`ifdef FG_ENGINE_PIPE2_EN
      .clk  (clk),
      .rst  (rst),
      .en   (adv_1),
`endif
      .mode (mode_q),
      .s    (in_bit[gi]),
      .a    (in_llr[(2*gi)*LLR_W +: LLR_W]),
      .b    (in_llr[(2*gi+1)*LLR_W +: LLR_W]),
      .res  (pe_res[gi])
    );
  end

  // mask_q stays fixed until the job's done, so it is valid for the
  // second stage as well and needs no pipeline copy.
  always_comb begin
    lanes_masked = '0;
    for (int unsigned i = 0; i < PE_NUM; i++) begin
      lanes_masked[i*LLR_W +: LLR_W] = mask_q[i] ? pe_res[i] : '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_llr_d   = out_llr_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
`ifdef FG_ENGINE_PIPE2_EN
    v1_d    = v1_q;
    last1_d = last1_q;
    if (adv_1) begin
      v1_d = in_fire;
      if (in_fire) last1_d = is_last_in;
    end
    if (adv_o) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        out_llr_d  = lanes_masked;
        out_mask_d = mask_q;
        out_last_d = last1_q;
      end
    end
`else
    if (adv_o) begin
      out_valid_d = in_fire;
      if (in_fire) begin
        out_llr_d  = lanes_masked;
        out_mask_d = mask_q;
        out_last_d = is_last_in;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      beats_m1_q  <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_llr_q   <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef FG_ENGINE_PIPE2_EN
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      beats_m1_q  <= beats_m1_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_llr_q   <= out_llr_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
`ifdef FG_ENGINE_PIPE2_EN
      v1_q        <= v1_d;
      last1_q     <= last1_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_llr   = out_llr_q;
  assign out_mask  = out_mask_q;
  assign out_last  = out_last_q;
  assign done      = done_w;

endmodule

// File: tb/tb_fg_engine.sv
// tb_fg_engine -- directed, table-driven bench for fg_engine (default
// parameters). Expected latency follows FG_ENGINE_PIPE2_EN.
module tb_fg_engine;
  import fg_engine_pkg::*;

`ifdef FG_ENGINE_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [7:0] PMAX = 8'(LLR_MAX);
  localparam logic [7:0] NMAX = 8'(-int'(LLR_MAX));

  logic         clk = 1'b0;
  logic         rst, start, flag_fg, in_valid, out_ready;
  logic [6:0]   len_log2;
  logic [127:0] in_llr;
  logic [7:0]   in_bit;
  logic         busy, in_ready, out_valid, out_last, done;
  logic [63:0]  out_llr;
  logic [7:0]   out_mask;

  always #5 clk = ~clk;

  fg_engine #(.LLR_W(8), .PE_NUM(8), .MAX_LEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .flag_fg(flag_fg), .len_log2(len_log2),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
    .in_bit(in_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_llr(out_llr), .out_mask(out_mask), .out_last(out_last), .done(done)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       mode;
    logic [6:0] len;
    logic [7:0] a, b, s, r0, r1, mask;
  } vec_t;
  vec_t vt[15];

  logic [127:0] b_llr [8];
  logic [7:0]   b_bit [8];
  logic [63:0]  b_exp [8];
  logic [7:0]   j_mask;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_ab(input logic [7:0] a, input logic [7:0] b);
    logic [127:0] w;
    for (int i = 0; i < 8; i++) begin
      w[16*i +: 8]     = a;
      w[16*i + 8 +: 8] = b;
    end
    return w;
  endfunction

  // r0 for lanes with s=0, r1 for s=1, zero for lanes outside the mask
  function automatic logic [63:0] pack_exp(input logic [7:0] r0, input logic [7:0] r1,
                                           input logic [7:0] s, input logic [7:0] m);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = m[i] ? (s[i] ? r1 : r0) : 8'h00;
    return w;
  endfunction

  task automatic begin_job(input logic mode, input logic [6:0] len);
    @(posedge clk); #1;
    start = 1'b1; flag_fg = mode; len_log2 = len;
    #1 chk("idle_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    #1 chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  // Streams nb beats from b_llr/b_bit, scoring outputs against b_exp/j_mask.
  task automatic run_job(input int nb, input bit rnd, input bit hold_start, input string nm);
    int ib = 0, ob = 0, cyc = 0, in0 = -1, first_out = -1;
    bit prev_stall = 0;
    logic [63:0] pl; logic [7:0] pm; logic plast;
    while (ob < nb && cyc < 400) begin
      @(posedge clk); #1;
      in_valid  = (ib < nb);
      in_llr    = b_llr[(ib < nb) ? ib : 0];
      in_bit    = b_bit[(ib < nb) ? ib : 0];
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = hold_start;
      #1;
      if (prev_stall) begin
        chk({nm, "_hold_llr"}, out_llr, pl);
        chk({nm, "_hold_mask"}, 64'(out_mask), 64'(pm));
        chk({nm, "_hold_last"}, 64'(out_last), 64'(plast));
      end
      if (out_valid && first_out < 0) begin
        first_out = cyc;
        chk({nm, "_latency"}, 64'(first_out), 64'(in0 + LAT));
      end
      if (out_valid && out_ready) begin
        chk({nm, "_llr"}, out_llr, b_exp[ob]);
        chk({nm, "_mask"}, 64'(out_mask), 64'(j_mask));
        chk({nm, "_last"}, 64'(out_last), 64'(ob == nb - 1));
        chk({nm, "_done"}, 64'(done), 64'(ob == nb - 1));
        ob++;
      end else begin
        chk({nm, "_no_done"}, 64'(done), 64'(0));
      end
      prev_stall = out_valid && !out_ready;
      pl = out_llr; pm = out_mask; plast = out_last;
      if (in_valid && in_ready) begin
        if (ib == 0) in0 = cyc;
        ib++;
      end
      cyc++;
    end
    if (ob < nb) chk({nm, "_timeout_beats"}, 64'(ob), 64'(nb));
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk({nm, "_idle_busy"}, 64'(busy), 64'(0));
    chk({nm, "_idle_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_idle_done"}, 64'(done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; flag_fg = 1'b0; len_log2 = '0;
    in_valid = 1'b0; in_llr = '0; in_bit = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_llr", out_llr, 64'(0));
    chk("rst_out_mask", 64'(out_mask), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;

    vt[0]  = '{MODE_F, 7'd3, 8'd5,    8'(-3),   8'h00, 8'(-3),  8'(-3),  8'hFF};
    vt[1]  = '{MODE_F, 7'd3, 8'h80,   8'(-100), 8'hFF, 8'd100,  8'd100,  8'hFF};
    vt[2]  = '{MODE_F, 7'd3, 8'h80,   8'h80,    8'h3C, PMAX,    PMAX,    8'hFF};
    vt[3]  = '{MODE_F, 7'd3, 8'(-7),  8'd20,    8'h00, 8'(-7),  8'(-7),  8'hFF};
    vt[4]  = '{MODE_F, 7'd3, 8'd0,    8'(-5),   8'h00, 8'd0,    8'd0,    8'hFF};
    vt[5]  = '{MODE_G, 7'd3, 8'd100,  8'd100,   8'h55, PMAX,    8'd0,    8'hFF};
    vt[6]  = '{MODE_G, 7'd3, 8'(-100),8'(-100), 8'h0F, NMAX,    8'd0,    8'hFF};
    vt[7]  = '{MODE_G, 7'd3, 8'h80,   8'd127,   8'hF0, 8'(-1),  PMAX,    8'hFF};
    vt[8]  = '{MODE_G, 7'd3, 8'd30,   8'(-50),  8'hAA, 8'(-20), 8'(-80), 8'hFF};
    vt[9]  = '{MODE_F, 7'd1, 8'd9,    8'(-4),   8'h00, 8'(-4),  8'(-4),  8'h03};
    vt[10] = '{MODE_G, 7'd0, 8'd3,    8'd4,     8'h01, 8'd7,    8'd1,    8'h01};
    vt[11] = '{MODE_F, 7'd2, 8'(-60), 8'(-61),  8'h00, 8'd60,   8'd60,   8'h0F};
    vt[12] = '{MODE_G, 7'd2, 8'h80,   8'h80,    8'h00, NMAX,    8'd0,    8'h0F};
    vt[13] = '{MODE_G, 7'd3, 8'd63,   8'd64,    8'h00, 8'd127,  8'd1,    8'hFF};
    vt[14] = '{MODE_G, 7'd3, 8'd64,   8'd64,    8'h00, PMAX,    8'd0,    8'hFF};

    for (int v = 0; v < 15; v++) begin
      b_llr[0] = pack_ab(vt[v].a, vt[v].b);
      b_bit[0] = vt[v].s;
      b_exp[0] = pack_exp(vt[v].r0, vt[v].r1, vt[v].s, vt[v].mask);
      j_mask   = vt[v].mask;
      begin_job(vt[v].mode, vt[v].len);
      run_job(1, 1'b0, 1'b0, $sformatf("vec%0d", v));
    end

    // Distinct lanes: lane0 f(5,-3) = -3, lane1 f(-128,-100) = 100, rest 0
    b_llr[0] = '0;
    b_llr[0][15:0]  = {8'hFD, 8'h05};
    b_llr[0][31:16] = {8'h9C, 8'h80};
    b_bit[0] = 8'h00;
    b_exp[0] = {48'h0, 8'h64, 8'hFD};
    j_mask   = 8'hFF;
    begin_job(MODE_F, 7'd3);
    run_job(1, 1'b0, 1'b0, "f_lanes");

    // 8-beat g job, saturating even lanes; start held high throughout,
    // including the done cycle, must be ignored
    for (int k = 0; k < 8; k++) begin
      b_llr[k] = pack_ab(8'd100, 8'd100);
      b_bit[k] = 8'hAA;
      b_exp[k] = pack_exp(PMAX, 8'd0, 8'hAA, 8'hFF);
    end
    begin_job(MODE_G, 7'd6);
    run_job(8, 1'b0, 1'b1, "g8_start_held");

    // Beat-dependent data under random backpressure
    for (int k = 0; k < 8; k++) begin
      b_llr[k] = pack_ab(8'(10*k + 1), 8'd5);
      b_bit[k] = 8'hAA;
      b_exp[k] = pack_exp(8'(10*k + 6), 8'(4 - 10*k), 8'hAA, 8'hFF);
    end
    begin_job(MODE_G, 7'd6);
    run_job(8, 1'b1, 1'b0, "g8_rnd_ready");

    // len_log2 beyond MAX_LEN clamps to 8 beats
    for (int k = 0; k < 8; k++) begin
      int e;
      e = (7*(k+1) < 50) ? 7*(k+1) : 50;
      b_llr[k] = pack_ab(8'(-7*(k+1)), 8'd50);
      b_bit[k] = 8'h00;
      b_exp[k] = pack_exp(8'(-e), 8'(-e), 8'h00, 8'hFF);
    end
    begin_job(MODE_F, 7'd9);
    run_job(8, 1'b0, 1'b0, "f_clamp");

    // Reset after four input beats of an 8-beat job
    for (int k = 0; k < 8; k++) begin
      b_llr[k] = pack_ab(8'(k + 2), 8'd20);
      b_bit[k] = 8'h0F;
      b_exp[k] = pack_exp(8'(22 + k), 8'(18 - k), 8'h0F, 8'hFF);
    end
    begin_job(MODE_G, 7'd6);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_llr = b_llr[k]; in_bit = b_bit[k]; out_ready = 1'b1;
      #1 chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    #1 chk("rst_mid_done_pre", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_in_ready0", 64'(in_ready), 64'(0));
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_out_llr", out_llr, 64'(0));
    chk("rst_mid_out_mask", 64'(out_mask), 64'(0));
    chk("rst_mid_out_last", 64'(out_last), 64'(0));
    chk("rst_mid_done", 64'(done), 64'(0));
    repeat (3) begin
      @(posedge clk); #2;
      chk("rst_mid_quiet_done", 64'(done), 64'(0));
      chk("rst_mid_quiet_valid", 64'(out_valid), 64'(0));
    end
    j_mask = 8'hFF;
    begin_job(MODE_G, 7'd6);
    run_job(8, 1'b0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
